fire4_expand3_ofm_writer: RTL and testbench
===========================================

Name: fire4_expand3_ofm_writer

Overview:
- Downstream stage of the fire4 expand-3x3 conv engine.
- On each sample pulse, captures the engine's DSP_NO parallel 16-bit output channels for one output pixel.
- Serialises them into the shared fire4 concat feature-map RAM in channel-major order, after the expand-1x1 channels.
- Drives ram_feedback high while draining, so the engine withholds its finish until every write has landed.

Parameters:
- WIDTH, 16, pixel data width
- DSP_NO, 128, channels delivered per sample pulse
- WOUT, 32, output feature-map side; the layer has WOUT*WOUT pixels
- CH_OFFSET, 128, first concat channel index owned by expand3 (expand1 owns 0..CH_OFFSET-1)
- AW, 18, RAM address width; must satisfy 2^AW >= (CH_OFFSET+DSP_NO)*WOUT*WOUT

Ports:
- clk, input, 1, single clock, rising edge
- rst, input, 1, synchronous active-high reset
- fire4_expand3_sample, input, 1, one-cycle pulse; ofm is valid in this cycle
- ofm, input, WIDTH x DSP_NO (unpacked array [0:DSP_NO-1]), per-channel post-ReLU outputs
- wr_en, output, 1, RAM write strobe
- wr_addr, output, AW, RAM write address
- wr_data, output, WIDTH, RAM write data
- ram_feedback, output, 1, busy: high while captured data is not fully written
- layer_done, output, 1, sticky: all WOUT*WOUT pixels written
- overflow, output, 1, sticky: a sample arrived while still draining

Behaviour:
- Reset (rst high at an edge): next cycle wr_en=0, wr_addr=0, wr_data=0, ram_feedback=0, layer_done=0, overflow=0. Also clears pix counter, ch counter and FSM, to IDLE. Reset mid-drain abandons remaining writes.
- FSM states: IDLE, DRAIN, DONE.
- IDLE:
  - On an edge with fire4_expand3_sample=1 and layer_done=0: capture all DSP_NO ofm words into a shadow buffer, set ch=0, go to DRAIN.
  - Otherwise stay in IDLE.
- DRAIN:
  - Each cycle, registered outputs are wr_en=1, wr_data=shadow[ch], wr_addr=(CH_OFFSET+ch)*WOUT*WOUT + pix.
  - The multiply uses constant WOUT*WOUT, computed at full width and then truncated to AW.
  - ch increments per cycle; ch=DSP_NO-1 is the last write.
- Latency:
  - Sample captured at edge t.
  - wr_en high for cycles t+1 .. t+DSP_NO; channel c is written in cycle t+1+c.
  - ram_feedback high for exactly the same cycles as wr_en.
- After the last write:
  - If pix == WOUT*WOUT-1: go to DONE and set layer_done at the same edge wr_en drops.
  - Else: pix <= pix+1, return to IDLE.
  - pix never wraps to 0 except by reset.
- DONE: layer_done stays 1, wr_en stays 0; further samples are ignored and do not raise overflow.
- Overflow:
  - Applies when fire4_expand3_sample=1 while in DRAIN, including the last-write cycle.
  - The sample is dropped, overflow sets and stays set until reset; the current drain continues unaffected.
  - Nominal engine period (KERNEL_DIM^2*CHIN+1 = 289 cycles) is greater than DSP_NO, so overflow never occurs in normal operation.
- Back-to-back: a sample in the first IDLE cycle after a drain (t+DSP_NO+1) is accepted normally.
- When wr_en=0, wr_data/wr_addr hold their last values; the RAM ignores them.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, then no samples for 50 cycles.
  - Required: wr_en=0, ram_feedback=0, layer_done=0, overflow=0 throughout.
- Single pixel:
  - ofm[c]=c+1, one sample pulse at cycle 10.
  - Required: wr_en high for cycles 11..138; cycle 11+c shows wr_data=c+1 and wr_addr=(128+c)*1024; ram_feedback mirrors wr_en.
- Second pixel addressing:
  - Two samples 289 cycles apart, ofm[c]=0x100+c on the second.
  - Required: second burst wr_addr=(128+c)*1024+1, data 0x100+c, overflow=0.
- Full layer:
  - 1024 samples at a 289-cycle period, random data.
  - Required: 131072 writes matching the scoreboard.
  - layer_done rises the cycle after the final write (addr 255*1024+1023), ram_feedback=0.
  - A 1025th sample produces no writes.
- Overflow:
  - Samples at cycle 10 and cycle 60.
  - Required: overflow=1 from cycle 61; exactly 128 writes, all from the first capture; next sample at cycle 200 is accepted with pix=1.
- Reset mid-drain:
  - Sample at cycle 10, rst=1 at cycle 50.
  - Required: wr_en=0 and ram_feedback=0 from cycle 51.
  - The next accepted sample writes addresses (128+c)*1024+0, i.e. pix restarts at 0.

Source files
------------

// File: rtl/fire4_expand3_ofm_writer.sv
// Captures one pixel's worth of expand-3x3 channel outputs and serialises them
// into the fire4 concat feature-map RAM, channel-major after the expand-1x1 block.
module fire4_expand3_ofm_writer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DSP_NO    = 128,
    parameter int unsigned WOUT      = 32,
    parameter int unsigned CH_OFFSET = 128,
    parameter int unsigned AW        = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fire4_expand3_sample,
    input  logic [WIDTH-1:0] ofm [0:DSP_NO-1],
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             ram_feedback,
    output logic             layer_done,
    output logic             overflow
);

    localparam int unsigned PIX_NO = WOUT * WOUT;
    localparam int unsigned CW     = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int unsigned PW     = (PIX_NO > 1) ? $clog2(PIX_NO) : 1;
    localparam logic [CW-1:0] CH_LAST  = CW'(DSP_NO - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_NO - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] shadow [0:DSP_NO-1];
    logic [CW-1:0]    ch;
    logic [CW-1:0]    ch_nxt;
    logic [CW-1:0]    ch_inc;
    logic [CW-1:0]    addr_ch;
    logic [PW-1:0]    pix;
    logic [PW-1:0]    pix_nxt;

    logic             accept;
    logic             last_wr;
    logic             wr_en_nxt;
    logic [AW-1:0]    wr_addr_nxt;
    logic [WIDTH-1:0] wr_data_nxt;
    logic             ram_feedback_nxt;
    logic             layer_done_nxt;
    logic             overflow_nxt;

    // ch always names the channel currently presented on the write port
    assign accept  = (state == IDLE) && fire4_expand3_sample;
    assign last_wr = (state == DRAIN) && (ch == CH_LAST);
    assign ch_inc  = ch + CW'(1);
    assign addr_ch = (state == DRAIN) ? ch_inc : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRAIN;
            DRAIN:   if (last_wr) state_nxt = (pix == PIX_LAST) ? DONE : IDLE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered write port, counters and status flags
    always_comb begin
        wr_en_nxt        = 1'b0;
        ram_feedback_nxt = 1'b0;
        wr_data_nxt      = wr_data;
        wr_addr_nxt      = AW'((32'(CH_OFFSET) + 32'(addr_ch)) * 32'(PIX_NO) + 32'(pix));
        ch_nxt           = ch;
        pix_nxt          = pix;
        layer_done_nxt   = layer_done;
        overflow_nxt     = overflow || ((state == DRAIN) && fire4_expand3_sample);
        case (state)
            IDLE: begin
                wr_addr_nxt = wr_addr;
                if (accept) begin
                    wr_en_nxt        = 1'b1;
                    ram_feedback_nxt = 1'b1;
                    wr_data_nxt      = ofm[0];
                    wr_addr_nxt      = AW'((32'(CH_OFFSET) + 32'(addr_ch)) * 32'(PIX_NO) + 32'(pix));
                    ch_nxt           = '0;
                end
            end
            DRAIN: begin
                if (last_wr) begin
                    wr_addr_nxt = wr_addr;
                    if (pix == PIX_LAST) begin
                        layer_done_nxt = 1'b1;
                    end else begin
                        pix_nxt = pix + PW'(1);
                    end
                end else begin
                    wr_en_nxt        = 1'b1;
                    ram_feedback_nxt = 1'b1;
                    wr_data_nxt      = shadow[ch_inc];
                    ch_nxt           = ch_inc;
                end
            end
            default: begin
                wr_addr_nxt = wr_addr;
            end
        endcase
    end

    // Registered outputs and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            ram_feedback <= 1'b0;
            layer_done   <= 1'b0;
            overflow     <= 1'b0;
            ch           <= '0;
            pix          <= '0;
        end else begin
            wr_en        <= wr_en_nxt;
            wr_addr      <= wr_addr_nxt;
            wr_data      <= wr_data_nxt;
            ram_feedback <= ram_feedback_nxt;
            layer_done   <= layer_done_nxt;
            overflow     <= overflow_nxt;
            ch           <= ch_nxt;
            pix          <= pix_nxt;
        end
    end

    // Shadow buffer frees the engine's output bus as soon as the sample is taken
    always_ff @(posedge clk) begin
        if (accept) begin
            shadow <= ofm;
        end
    end

endmodule

// File: tb/tb_fire4_expand3_ofm_writer.sv
// Bench for fire4_expand3_ofm_writer: scoreboard of expected RAM writes plus
// a vector table of sample pulses with expected acceptance and status flags.
module tb_fire4_expand3_ofm_writer;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned DSP_NO    = 128;
    localparam int unsigned WOUT      = 8;
    localparam int unsigned CH_OFFSET = 128;
    localparam int unsigned AW        = 18;
    localparam int unsigned WW        = WOUT * WOUT;

    logic             clk;
    logic             rst;
    logic             sample;
    logic [WIDTH-1:0] ofm [0:DSP_NO-1];
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             ram_feedback;
    logic             layer_done;
    logic             overflow;

    fire4_expand3_ofm_writer #(
        .WIDTH    (WIDTH),
        .DSP_NO   (DSP_NO),
        .WOUT     (WOUT),
        .CH_OFFSET(CH_OFFSET),
        .AW       (AW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .fire4_expand3_sample(sample),
        .ofm                 (ofm),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .ram_feedback        (ram_feedback),
        .layer_done          (layer_done),
        .overflow            (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    typedef struct {
        bit          rst;
        int          gap;
        logic [15:0] base;
        bit          acc;
        int          pix;
        bit          ovf;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs [0:9];
    int   n_cmp;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-port monitor, run once per cycle at the falling edge
    task automatic monitor();
        wr_t e;
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write at %0t",
                         wr_addr, wr_data, $time);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
        check("ram_feedback_eq_wr_en", 32'(ram_feedback), 32'(wr_en));
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        sb.delete();
        tick();
        rst = 1'b0;
        check("reset_state", {26'd0, wr_en, ram_feedback, layer_done, overflow, 2'd0}, 32'd0);
        check("reset_addr_data", {wr_addr, wr_data[13:0]}, 32'd0);
    endtask

    task automatic set_ramp(input logic [15:0] base);
        for (int c = 0; c < int'(DSP_NO); c++) ofm[c] = WIDTH'(base + 16'(c));
    endtask

    task automatic set_rand();
        for (int c = 0; c < int'(DSP_NO); c++) ofm[c] = WIDTH'($urandom);
    endtask

    // One-cycle sample pulse; expected writes queued from the data on the bus
    task automatic pulse(input bit acc, input int pix);
        wr_t e;
        if (acc) begin
            for (int c = 0; c < int'(DSP_NO); c++) begin
                e.addr = AW'((int'(CH_OFFSET) + c) * int'(WW) + pix);
                e.data = ofm[c];
                sb.push_back(e);
            end
        end
        sample = 1'b1;
        tick();
        sample = 1'b0;
        set_rand();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        sample = 1'b0;
        set_rand();

        // Pulse table: gap cycles, data ramp base, expected acceptance, pixel, overflow
        vecs[0] = '{1'b1,   8, 16'h0001, 1'b1, 0, 1'b0};
        vecs[1] = '{1'b0, 288, 16'h0100, 1'b1, 1, 1'b0};
        vecs[2] = '{1'b0, 128, 16'h0200, 1'b1, 2, 1'b0};
        vecs[3] = '{1'b0, 127, 16'h0300, 1'b0, 0, 1'b1};
        vecs[4] = '{1'b0,   0, 16'h0400, 1'b1, 3, 1'b1};
        vecs[5] = '{1'b0,  50, 16'h0500, 1'b0, 0, 1'b1};
        vecs[6] = '{1'b0, 200, 16'h0600, 1'b1, 4, 1'b1};
        vecs[7] = '{1'b1,   8, 16'h1000, 1'b1, 0, 1'b0};
        vecs[8] = '{1'b0,  49, 16'h2000, 1'b0, 0, 1'b1};
        vecs[9] = '{1'b0, 140, 16'h3000, 1'b1, 1, 1'b1};

        // Reset then idle
        do_reset();
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_quiet", {28'd0, wr_en, ram_feedback, layer_done, overflow}, 32'd0);
        end

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].rst) begin
                ticks(140);
                check("drain_complete", 32'(sb.size()), 32'd0);
                do_reset();
            end
            ticks(vecs[v].gap);
            set_ramp(vecs[v].base);
            pulse(vecs[v].acc, vecs[v].pix);
            check("accept_wr_en", 32'(wr_en), vecs[v].acc ? 32'd1 : 32'(wr_en && !vecs[v].acc));
            check("overflow_flag", 32'(overflow), 32'(vecs[v].ovf));
        end
        ticks(140);
        check("drain_complete", 32'(sb.size()), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Reset mid-drain abandons remaining writes and restarts pixel count
        do_reset();
        ticks(8);
        set_ramp(16'h4000);
        pulse(1'b1, 0);
        ticks(39);
        rst = 1'b1;
        tick();
        sb.delete();
        rst = 1'b0;
        check("middrain_reset", {26'd0, wr_en, ram_feedback, layer_done, overflow, 2'd0}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("middrain_quiet", {30'd0, wr_en, ram_feedback}, 32'd0);
        end
        set_ramp(16'h5000);
        pulse(1'b1, 0);
        ticks(140);
        check("drain_complete", 32'(sb.size()), 32'd0);

        // Full layer with alternating nominal and back-to-back periods
        do_reset();
        for (int p = 0; p < int'(WW); p++) begin
            ticks((p == 0) ? 8 : ((p % 2 == 1) ? 128 : 288));
            check("layer_done_early", 32'(layer_done), 32'd0);
            set_rand();
            pulse(1'b1, p);
        end
        ticks(127);
        check("last_write_pending", {30'd0, wr_en, layer_done}, 32'd2);
        tick();
        check("layer_done_rise", {29'd0, layer_done, wr_en, ram_feedback}, 32'd4);
        check("layer_drained", 32'(sb.size()), 32'd0);
        ticks(10);
        pulse(1'b0, 0);
        ticks(140);
        check("post_layer_no_writes", 32'(sb.size()), 32'd0);
        check("post_layer_flags", {30'd0, layer_done, overflow}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
